// File: rtl/ahb_keypad_scanner.sv
// AHB-Lite keypad scanner: scans a 4x4 active-low matrix, debounces per key and queues key events.
// Optional macro KEYPAD_RELEASE_EVENT_EN also queues release events (DATA bit 4 = 1).
module ahb_keypad_scanner #(
  parameter int SCAN_DIV   = 50000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic        IRQ,
  output logic [3:0]  ROW,
  input  logic [3:0]  COL
);
  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_NEXT, S_EVAL} scan_state_t;

  scan_state_t      state_q, state_d;
  logic [1:0]       row_q, row_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       col_s1, col_s2;
  logic [15:0]      frame_q, acc_q, acc_nx, chg, pend_q, pend_load;
  logic [3:0]       cnt_q [16];
  logic [3:0]       cnt_nx [16];
  logic             eval_load, sample, push_valid, push_rel;
  logic [3:0]       push_sel;

  logic             a_valid, a_write;
  logic [1:0]       a_addr;
  logic [1:0]       ctrl_q;
  logic             ovf_q, irq_q;
  logic [4:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             empty, full, do_wr, pop, flush, clr_ovf, do_push, ovf_set;
  logic [31:0]      rd_data;
  logic             unused_ok;

  assign unused_ok = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HSIZE, HWDATA[31:2]};

  // Address phase is taken when HSEL & HREADY & HTRANS[1]; the data phase is the next
  // HREADY-qualified cycle, where writes commit and DATA reads pop at its closing edge.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_valid <= 1'b0;
      a_write <= 1'b0;
      a_addr  <= 2'd0;
    end else if (HREADY) begin
      a_valid <= HSEL & HTRANS[1];
      a_write <= HWRITE;
      a_addr  <= HADDR[3:2];
    end
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign do_wr   = a_valid & a_write & HREADY;
  assign pop     = a_valid & ~a_write & HREADY & (a_addr == 2'd0) & ~empty;
  assign flush   = do_wr & (a_addr == 2'd3) & HWDATA[1];
  assign clr_ovf = do_wr & (a_addr == 2'd3) & HWDATA[0];
  assign do_push = push_valid & ~flush & (~full | pop);
  assign ovf_set = push_valid & ~flush & full & ~pop;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_q  <= 2'b00;
      ovf_q   <= 1'b0;
      irq_q   <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_wr && a_addr == 2'd2) ctrl_q <= HWDATA[1:0];
      if (ovf_set) ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
      irq_q <= ctrl_q[1] & (~empty | ovf_q);
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (do_push) begin
          mem_q[wr_ptr] <= {push_rel, push_sel};
          wr_ptr        <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count_q <= count_q + CNT_W'(do_push) - CNT_W'(pop);
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (a_addr)
      2'd0: if (!empty) rd_data = {23'd0, 1'b1, 3'd0, mem_q[rd_ptr]};
      2'd1: rd_data = 32'(count_q) | {21'd0, ovf_q, full, empty, 8'd0};
      2'd2: rd_data = {30'd0, ctrl_q};
      default: rd_data = '0;
    endcase
  end

  assign HRDATA    = (a_valid & ~a_write) ? rd_data : 32'd0;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign IRQ       = irq_q;

  // Columns idle high through the pull-ups.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      col_s1 <= 4'hF;
      col_s2 <= 4'hF;
    end else begin
      col_s1 <= COL;
      col_s2 <= col_s1;
    end
  end

  assign sample = (state_q == S_DRIVE) && (div_q == '0) && ctrl_q[0];
  assign ROW    = (state_q == S_DRIVE) ? ~(4'b0001 << row_q) : 4'hF;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    div_d     = div_q;
    eval_load = 1'b0;
    case (state_q)
      S_IDLE: if (ctrl_q[0]) begin
        state_d = S_DRIVE;
        row_d   = 2'd0;
        div_d   = DIV_W'(SCAN_DIV - 1);
      end
      S_DRIVE: if (div_q == '0) state_d = S_NEXT;
               else div_d = div_q - 1'b1;
      S_NEXT: if (row_q == 2'd3) begin
        state_d   = S_EVAL;
        eval_load = 1'b1;
      end else begin
        state_d = S_DRIVE;
        row_d   = row_q + 2'd1;
        div_d   = DIV_W'(SCAN_DIV - 1);
      end
      default: if (pend_q == '0) begin
        state_d = S_DRIVE;
        row_d   = 2'd0;
        div_d   = DIV_W'(SCAN_DIV - 1);
      end
    endcase
    if (!ctrl_q[0]) begin
      state_d   = S_IDLE;
      div_d     = '0;
      eval_load = 1'b0;
    end
  end

  // Frame bit 1 means pressed; a key toggles its accepted state after DEBOUNCE differing frames.
  always_comb begin
    acc_nx = acc_q;
    chg    = '0;
    for (int k = 0; k < 16; k++) begin
      cnt_nx[k] = '0;
      if (frame_q[k] != acc_q[k]) begin
        if (cnt_q[k] + 4'd1 == 4'(DEBOUNCE)) begin
          acc_nx[k] = ~acc_q[k];
          chg[k]    = 1'b1;
        end else begin
          cnt_nx[k] = cnt_q[k] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    push_sel = '0;
    for (int k = 15; k >= 0; k--) if (pend_q[k]) push_sel = 4'(k);
  end

  assign push_valid = (state_q == S_EVAL) && (pend_q != '0);

`ifdef KEYPAD_RELEASE_EVENT_EN
  assign pend_load = chg;
  assign push_rel  = ~acc_q[push_sel];
`else
  assign pend_load = chg & acc_nx;
  assign push_rel  = 1'b0;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      row_q   <= 2'd0;
      div_q   <= '0;
      frame_q <= '0;
      acc_q   <= '0;
      pend_q  <= '0;
      for (int k = 0; k < 16; k++) cnt_q[k] <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      div_q   <= div_d;
      if (sample) frame_q[{row_q, 2'b00} +: 4] <= ~col_s2;
      if (state_q == S_IDLE) pend_q <= '0;
      else if (eval_load) pend_q <= pend_load;
      else if (push_valid) pend_q[push_sel] <= 1'b0;
      if (eval_load) begin
        acc_q <= acc_nx;
        for (int k = 0; k < 16; k++) cnt_q[k] <= cnt_nx[k];
      end
    end
  end
endmodule

// File: tb/tb_ahb_keypad_scanner.sv
// Bench for ahb_keypad_scanner: register table, hand-timed corner cases, then random key traffic vs a frame-level model.
module tb_ahb_keypad_scanner;
  localparam int SCAN_DIV   = 4;
  localparam int DEBOUNCE   = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int BOUND      = 400;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'd2;
  logic [31:0] HWDATA = '0;
  logic        HREADY = 1'b1;
  logic        HREADYOUT, HRESP, IRQ;
  logic [31:0] HRDATA;
  logic [3:0]  ROW, COL;
  logic [15:0] keys = '0;

  int n_cmp = 0;
  int n_bad = 0;

  // Frame-level reference model
  int         acc [16];
  int         cnt [16];
  logic [4:0] exp_q[$];
  bit         m_ovf;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[14];

  ahb_keypad_scanner #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .IRQ(IRQ),
    .ROW(ROW), .COL(COL)
  );

  always #5 HCLK = ~HCLK;

  // Keypad matrix without diodes: a pressed key shorts its column to the driven row.
  always_comb begin
    COL = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!ROW[r])
        for (int c = 0; c < 4; c++)
          if (keys[r*4+c]) COL[c] = 1'b0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    HSEL   = 1'($urandom_range(0, 1));
    HTRANS = 2'b00;
    HWRITE = 1'($urandom_range(0, 1));
  endtask

  task automatic set_addr(input logic [3:0] a, input logic wr);
    logic [31:0] rnd;
    rnd    = $urandom();
    HSEL   = 1'b1;
    HTRANS = {1'b1, 1'($urandom_range(0, 1))};
    HWRITE = wr;
    HSIZE  = 3'($urandom_range(0, 2));
    HADDR  = {rnd[31:4], a[3:2], rnd[1:0]};
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    set_addr(a, 1'b1);
    @(negedge HCLK);
    bus_idle();
    HWDATA = d;
    @(negedge HCLK);
  endtask

  task automatic read_check(input string name, input logic [3:0] a, input logic [31:0] exp);
    set_addr(a, 1'b0);
    HWDATA = $urandom();
    @(negedge HCLK);
    bus_idle();
    check(name, HRDATA, exp);
    check("resp", {30'd0, HRESP, HREADYOUT}, 32'h1);
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound of %0d cycles expired", name, BOUND);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  task automatic wait_frame_start();
    int n = 0;
    while (ROW == 4'b1110 && n < BOUND) begin @(negedge HCLK); n++; end
    while (ROW != 4'b1110 && n < BOUND) begin @(negedge HCLK); n++; end
    if (n >= BOUND) timeout("frame_start");
  endtask

  task automatic frame(input logic [15:0] k);
    wait_frame_start();
    keys = k;
  endtask

  task automatic settle();
    frame(16'h0000);
    frame(16'h0000);
    frame(16'h0000);
    wait_frame_start();
    bus_write(4'hC, 32'h3);
    read_check("settle_status", 4'h4, 32'h100);
  endtask

  task automatic model_push(input int k, input bit rel);
    if (exp_q.size() < FIFO_DEPTH) exp_q.push_back({rel, 4'(k)});
    else m_ovf = 1'b1;
  endtask

  task automatic model_frame(input logic [15:0] k);
    for (int i = 0; i < 16; i++) begin
      if (int'(k[i]) != acc[i]) begin
        cnt[i]++;
        if (cnt[i] == DEBOUNCE) begin
          acc[i] = int'(k[i]);
          cnt[i] = 0;
          if (k[i]) model_push(i, 1'b0);
`ifdef KEYPAD_RELEASE_EVENT_EN
          else model_push(i, 1'b1);
`endif
        end
      end else begin
        cnt[i] = 0;
      end
    end
  endtask

  function automatic logic [31:0] model_status();
    int s = exp_q.size();
    return 32'(s) | ((s == 0) ? 32'h100 : 32'h0) | ((s == FIFO_DEPTH) ? 32'h200 : 32'h0)
         | (m_ovf ? 32'h400 : 32'h0);
  endfunction

  initial begin
    logic [15:0] cur;
    logic [4:0]  e;
    int          n;

    // Reset
    repeat (4) @(negedge HCLK);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_row", {28'd0, ROW}, 32'hF);
    check("rst_irq", {31'd0, IRQ}, 32'h0);
    check("rst_ready_resp", {30'd0, HRESP, HREADYOUT}, 32'h1);
    HRESETn = 1'b1;
    @(negedge HCLK);

    // Register table
    vecs[0]  = '{1'b0, 4'h0, 32'h0,        32'h000, "rst_data"};
    vecs[1]  = '{1'b0, 4'h4, 32'h0,        32'h100, "rst_status"};
    vecs[2]  = '{1'b0, 4'h8, 32'h0,        32'h000, "rst_ctrl"};
    vecs[3]  = '{1'b0, 4'hC, 32'h0,        32'h000, "rst_clear"};
    vecs[4]  = '{1'b1, 4'h8, 32'hFFFFFFFE, 32'h0,   "wr_ctrl"};
    vecs[5]  = '{1'b0, 4'h8, 32'h0,        32'h002, "ctrl_rb"};
    vecs[6]  = '{1'b1, 4'h0, 32'h0000FFFF, 32'h0,   "wr_data"};
    vecs[7]  = '{1'b0, 4'h0, 32'h0,        32'h000, "data_ro"};
    vecs[8]  = '{1'b1, 4'h4, 32'h00000605, 32'h0,   "wr_status"};
    vecs[9]  = '{1'b0, 4'h4, 32'h0,        32'h100, "status_ro"};
    vecs[10] = '{1'b1, 4'hC, 32'h3,        32'h0,   "wr_clear"};
    vecs[11] = '{1'b0, 4'hC, 32'h0,        32'h000, "clear_rd0"};
    vecs[12] = '{1'b1, 4'h8, 32'h0,        32'h0,   "wr_ctrl0"};
    vecs[13] = '{1'b0, 4'h8, 32'h0,        32'h000, "ctrl_rb0"};
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
      else read_check(vecs[i].name, vecs[i].addr, vecs[i].exp);
    end
    check("irq_idle", {31'd0, IRQ}, 32'h0);

    // Press key 6 (row1/col2) for three frames
    bus_write(4'h8, 32'h3);
    frame(16'h0040);
    frame(16'h0040);
    frame(16'h0040);
    wait_frame_start();
    check("press_irq", {31'd0, IRQ}, 32'h1);
    read_check("press_data", 4'h0, 32'h106);
    read_check("press_data_empty", 4'h0, 32'h000);
    check("irq_lag", {31'd0, IRQ}, 32'h1);
    @(negedge HCLK);
    check("irq_clear", {31'd0, IRQ}, 32'h0);
    settle();

    // One-frame glitch must not be accepted
    frame(16'h0001);
    frame(16'h0000);
    frame(16'h0000);
    wait_frame_start();
    read_check("glitch_status", 4'h4, 32'h100);

    // Five presses in one frame overflow a 4-deep FIFO
    frame(16'h001F);
    frame(16'h001F);
    wait_frame_start();
    read_check("ovf_status", 4'h4, 32'h604);
    check("ovf_irq", {31'd0, IRQ}, 32'h1);
    bus_write(4'hC, 32'h1);
    read_check("ovf_cleared", 4'h4, 32'h204);

    // DATA pop lands on the same edge as the push of key 8
    frame(16'h011F);
    wait_frame_start();
    n = 0;
    while (ROW != 4'b0111 && n < BOUND) begin @(negedge HCLK); n++; end
    while (ROW == 4'b0111 && n < BOUND) begin @(negedge HCLK); n++; end
    if (n >= BOUND) timeout("row3_end");
    read_check("pushpop_data", 4'h0, 32'h100);
    wait_frame_start();
    read_check("pushpop_status", 4'h4, 32'h204);
    read_check("pushpop_next", 4'h0, 32'h101);
    read_check("pushpop_count", 4'h4, 32'h003);
    bus_write(4'hC, 32'h2);
    read_check("flush_status", 4'h4, 32'h100);
    read_check("flush_data", 4'h0, 32'h000);

    // Scan disable mid-DRIVE
    wait_frame_start();
    bus_write(4'h8, 32'h2);
    check("row_still_driven", {28'd0, ROW}, 32'hE);
    @(negedge HCLK);
    check("row_idle", {28'd0, ROW}, 32'hF);
    @(negedge HCLK);
    check("row_stays_idle", {28'd0, ROW}, 32'hF);
    bus_write(4'h8, 32'h3);
    settle();

    // Press then release key 0
    frame(16'h0001);
    frame(16'h0001);
    frame(16'h0000);
    frame(16'h0000);
    wait_frame_start();
    read_check("rel_press", 4'h0, 32'h100);
`ifdef KEYPAD_RELEASE_EVENT_EN
    read_check("rel_release", 4'h0, 32'h110);
`else
    read_check("rel_none", 4'h0, 32'h000);
`endif
    settle();

    // Random key traffic against the frame model
    for (int i = 0; i < 16; i++) begin acc[i] = 0; cnt[i] = 0; end
    exp_q.delete();
    m_ovf = 1'b0;
    cur = '0;
    for (int it = 0; it < 60; it++) begin
      wait_frame_start();
      model_frame(cur);
      n = $urandom_range(0, 7);
      if (n == 0) cur = 16'($urandom());
      else if (n < 5) begin
        int idx = $urandom_range(0, 15);
        cur[idx] = ~cur[idx];
      end
      keys = cur;
      check("rnd_irq", {31'd0, IRQ}, {31'd0, (exp_q.size() != 0) || m_ovf});
      read_check("rnd_status", 4'h4, model_status());
      n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++) begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          read_check("rnd_data", 4'h0, 32'h100 | 32'(e));
        end else begin
          read_check("rnd_data_empty", 4'h0, 32'h000);
        end
      end
      if ($urandom_range(0, 7) == 0) begin
        bus_write(4'hC, 32'h1);
        m_ovf = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ahb_keypad_scanner.md
Name: ahb_keypad_scanner

Overview:
AHB-Lite responder (slave) that scans the 4x4 matrix keypad on ROW/COL and exposes debounced key events to the Cortex-M0 through a small register file. It sits behind the AHBLite bus decoder alongside the other peripherals. It drives one IRQ line into the M0 IRQ vector when key events are pending. Zero-wait-state, OKAY-only responder.

Parameters:
SCAN_DIV, 50000, HCLK cycles each row is driven before the columns are sampled (>=4)
DEBOUNCE, 4, consecutive full scan frames a key state must hold before it is accepted (1..15)
FIFO_DEPTH, 4, key event FIFO entries; power of two, 2..16

Ports:
HCLK  input  1  system clock
HRESETn  input  1  asynchronous active-low reset
HSEL  input  1  slave select from bus decoder
HADDR  input  32  address; only [3:2] decoded
HTRANS  input  2  transfer type; NONSEQ/SEQ valid when HTRANS[1]=1
HWRITE  input  1  1=write
HSIZE  input  3  ignored; all accesses treated as 32-bit
HWDATA  input  32  write data (data phase)
HREADY  input  1  bus-wide ready; qualifies the address phase
HREADYOUT  output  1  always 1
HRESP  output  1  always 0 (OKAY)
HRDATA  output  32  read data (data phase)
IRQ  output  1  level interrupt
ROW  output  4  row drive, active-low one-hot
COL  input  4  column sense, active-low, external pull-ups

Behaviour:
- Reset: HRDATA=0, HREADYOUT=1, HRESP=0, IRQ=0, ROW=4'b1111, FIFO empty, all registers 0, scanner idle.
- AHB address phase is accepted when HSEL&HREADY&HTRANS[1]. Register addr[3:2], write flag, and valid bit on that edge. Act in the following data phase. Back-to-back transfers are supported.
- Register map (word offsets):
  - 0x00 DATA (RO): [3:0] key code = row*4+col; [4] release flag (0 unless the option is enabled); [8] valid=!empty. A read with valid=1 pops one entry at the end of the data phase. A read when empty returns 0 and does not pop.
  - 0x04 STATUS (RO): [4:0] fill count; [8] empty; [9] full; [10] overflow (sticky).
  - 0x08 CTRL (RW): [0] scan enable; [1] IRQ enable. Reset value 0.
  - 0x0C CLEAR (WO, reads 0): bit0=1 clears overflow; bit1=1 flushes the FIFO.
- HRDATA is combinational from the latched address and the current state during the data phase. A DATA read pop and the HRDATA value come from the same head entry.
- COL passes through a 2-FF synchronizer before use.
- Scanner FSM:
  - IDLE: ROW=1111. Go to DRIVE with row=0 when CTRL[0]=1.
  - DRIVE: row r is driven low and a divider counts SCAN_DIV-1..0. At 0, sample the synchronized COL into frame bits [4r+3:4r].
  - NEXT: r=r+1. After r=3, go to EVAL, then back to DRIVE with row 0.
  - Clearing CTRL[0] at any point returns to IDLE on the next cycle and zeroes the divider. Debounce state is kept.
- EVAL, per key k:
  - Per-key counter increments while the new frame bit differs from the accepted state, and resets to 0 when it matches.
  - When the counter reaches DEBOUNCE, the accepted state toggles and the counter resets.
  - A 0->1 accepted transition (press) pushes code k.
  - Multiple keys changing in one frame are pushed in ascending k order, one per cycle; EVAL holds until all are pushed.
- FIFO:
  - Push when full and no simultaneous pop: entry dropped, overflow set.
  - Simultaneous push and pop when full: both succeed, count unchanged, no overflow.
  - Flush wins over a same-cycle push.
- IRQ = CTRL[1] & (!empty | overflow), registered, so one cycle of latency.
- HWDATA writes to DATA/STATUS are ignored. Unaligned/size are ignored.

Optional Feature:
KEYPAD_RELEASE_EVENT_EN
- Defined: 1->0 accepted transitions also push an entry with bit[4]=1. Press and release for the same frame are ordered by k.
- Undefined: releases update debounce state only; bit[4] reads 0.

Test Plan:
- Reset, then read 0x00/0x04/0x08 -> 0x0, 0x100, 0x0. HREADYOUT=1 and HRESP=0 throughout.
- SCAN_DIV=4, DEBOUNCE=2, CTRL=0x3, hold key row1/col2 low for 3 frames -> IRQ=1. DATA read returns 0x106. Next DATA read returns 0x000 and IRQ=0 one cycle later.
- Key held low for 1 frame only (glitch) -> no FIFO entry, STATUS=0x100.
- Five distinct key presses with FIFO_DEPTH=4, no reads -> STATUS=0x604 (full+overflow, count 4). Write CLEAR=1 -> STATUS=0x204.
- Full FIFO: DATA read in the same cycle as a new push -> count stays 4, overflow stays 0. Then CLEAR=2 -> STATUS=0x100.
- Clear CTRL[0] mid-DRIVE -> ROW=1111 next cycle. With KEYPAD_RELEASE_EVENT_EN, press then release key 0 -> reads 0x100 then 0x110.
